ex_mem_stage: RTL and testbench

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/ex_mem_stage_pkg.sv | 26 ++
 rtl/ex_mem_stage_mem_access_dec.sv | 55 +++++
 rtl/ex_mem_stage.sv | 82 ++++++++
 tb/tb_ex_mem_stage.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_stage_pkg.sv
// Shared CPU definitions used by the M stage and the W-stage load extender.
// Holds the memory opcode constants and the load extension encodings.
package ex_mem_stage_pkg;

   localparam logic [5:0] OP_SW  = 6'h2B;
   localparam logic [5:0] OP_SH  = 6'h29;
   localparam logic [5:0] OP_SB  = 6'h28;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LHU = 6'h25;
   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LBU = 6'h24;

   typedef enum logic [2:0] {
      EXT_W  = 3'b000,
      EXT_H  = 3'b001,
      EXT_B  = 3'b010,
      EXT_HU = 3'b011,
      EXT_BU = 3'b100
   } load_ext_e;

   function automatic logic is_store(input logic [5:0] op);
      return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
   endfunction

endpackage

// File: rtl/ex_mem_stage_mem_access_dec.sv
// mem_access_dec: decodes the instruction held in M into data-memory byte
// enables, the load extension select for W, and a misalignment flag.
// Ports:
//   Instr_M    in  32  instruction in M
//   addr_lo    in  2   aluOut_M[1:0]
//   valid_M    in  1   M holds a real instruction
//   ByteEn     out 4   byte write enables (zero for loads, bubbles, misaligned)
//   Load_extOp out 3   load extension select (EXT_W when not a valid aligned load)
//   misalign_M out 1   access is misaligned for its size
module mem_access_dec
   import ex_mem_stage_pkg::*;
(
   input  logic [31:0] Instr_M,
   input  logic [1:0]  addr_lo,
   input  logic        valid_M,
   output logic [3:0]  ByteEn,
   output logic [2:0]  Load_extOp,
   output logic        misalign_M
);

   logic [5:0] op;
   assign op = Instr_M[31:26];

   always_comb begin
      ByteEn     = 4'b0000;
      Load_extOp = EXT_W;
      misalign_M = 1'b0;
      if (valid_M) begin
         unique case (op)
            OP_SW: begin
               if (addr_lo != 2'b00) misalign_M = 1'b1;
               else                  ByteEn     = 4'b1111;
            end
            OP_SH: begin
               if (addr_lo[0]) misalign_M = 1'b1;
               else            ByteEn     = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            OP_SB:  ByteEn = 4'b0001 << addr_lo;
            OP_LW:  misalign_M = (addr_lo != 2'b00);
            OP_LH: begin
               if (addr_lo[0]) misalign_M = 1'b1;
               else            Load_extOp = EXT_H;
            end
            OP_LHU: begin
               if (addr_lo[0]) misalign_M = 1'b1;
               else            Load_extOp = EXT_HU;
            end
            OP_LB:  Load_extOp = EXT_B;
            OP_LBU: Load_extOp = EXT_BU;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: E->M pipeline register with data-memory access decode.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   stall, flush                    hold / insert bubble (flush wins)
//   PC_E, Instr_E, rtData_E, aluOut_E, sb_E   E-stage inputs
//   PC_M, PC_M8, Instr_M, rtData_M, aluOut_M, sb_M, valid_M   registered M state
//   ByteEn, storeData, Load_extOp, misalign_M  decode from M registers only
module ex_mem_stage
   import ex_mem_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter int          SB_W     = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            flush,
   input  logic [31:0]     PC_E,
   input  logic [31:0]     Instr_E,
   input  logic [31:0]     rtData_E,
   input  logic [31:0]     aluOut_E,
   input  logic [SB_W-1:0] sb_E,
   output logic [31:0]     PC_M,
   output logic [31:0]     PC_M8,
   output logic [31:0]     Instr_M,
   output logic [31:0]     rtData_M,
   output logic [31:0]     aluOut_M,
   output logic [SB_W-1:0] sb_M,
   output logic            valid_M,
   output logic [3:0]      ByteEn,
   output logic [31:0]     storeData,
   output logic [2:0]      Load_extOp,
   output logic            misalign_M
);

   always_ff @(posedge clk) begin
      if (reset) begin
         PC_M     <= RESET_PC;
         PC_M8    <= RESET_PC + 32'd8;
         Instr_M  <= '0;
         rtData_M <= '0;
         aluOut_M <= '0;
         sb_M     <= '0;
         valid_M  <= 1'b0;
      end else if (flush) begin
         // PC survives the bubble so exception handling can still see it.
         PC_M     <= PC_E;
         PC_M8    <= PC_E + 32'd8;
         Instr_M  <= '0;
         rtData_M <= '0;
         aluOut_M <= '0;
         sb_M     <= '0;
         valid_M  <= 1'b0;
      end else if (!stall) begin
         PC_M     <= PC_E;
         PC_M8    <= PC_E + 32'd8;
         Instr_M  <= Instr_E;
         rtData_M <= rtData_E;
         aluOut_M <= aluOut_E;
         sb_M     <= sb_E;
         valid_M  <= 1'b1;
      end
   end

   mem_access_dec u_dec (
      .Instr_M    (Instr_M),
      .addr_lo    (aluOut_M[1:0]),
      .valid_M    (valid_M),
      .ByteEn     (ByteEn),
      .Load_extOp (Load_extOp),
      .misalign_M (misalign_M)
   );

   always_comb begin
      unique case (Instr_M[31:26])
         OP_SH:   storeData = {2{rtData_M[15:0]}};
         OP_SB:   storeData = {4{rtData_M[7:0]}};
         default: storeData = rtData_M;
      endcase
   end

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;

   logic        clk = 1'b0;
   logic        reset, stall, flush;
   logic [31:0] PC_E, Instr_E, rtData_E, aluOut_E;
   logic [0:0]  sb_E;
   logic [31:0] PC_M, PC_M8, Instr_M, rtData_M, aluOut_M, storeData;
   logic [0:0]  sb_M;
   logic        valid_M, misalign_M;
   logic [3:0]  ByteEn;
   logic [2:0]  Load_extOp;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ex_mem_stage dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .PC_E(PC_E), .Instr_E(Instr_E), .rtData_E(rtData_E), .aluOut_E(aluOut_E), .sb_E(sb_E),
      .PC_M(PC_M), .PC_M8(PC_M8), .Instr_M(Instr_M), .rtData_M(rtData_M), .aluOut_M(aluOut_M),
      .sb_M(sb_M), .valid_M(valid_M), .ByteEn(ByteEn), .storeData(storeData),
      .Load_extOp(Load_extOp), .misalign_M(misalign_M)
   );

   // reference model: the architectural content of the M stage
   logic [31:0] m_pc, m_instr, m_rt, m_alu;
   logic [0:0]  m_sb;
   logic        m_valid;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      if (reset) begin
         m_pc = 32'h3000; m_instr = 0; m_rt = 0; m_alu = 0; m_sb = 0; m_valid = 0;
      end else if (flush) begin
         m_pc = PC_E; m_instr = 0; m_rt = 0; m_alu = 0; m_sb = 0; m_valid = 0;
      end else if (!stall) begin
         m_pc = PC_E; m_instr = Instr_E; m_rt = rtData_E; m_alu = aluOut_E;
         m_sb = sb_E; m_valid = 1;
      end
   endtask

   task automatic check_model();
      int op, sz, a, mis, st, ext;
      int unsigned be, sd;
      op = int'(m_instr[31:26]);
      a  = int'(m_alu % 4);
      case (op)
         'h2B, 'h23:        sz = 4;
         'h29, 'h21, 'h25:  sz = 2;
         'h28, 'h20, 'h24:  sz = 1;
         default:           sz = 0;
      endcase
      st  = (op == 'h2B || op == 'h29 || op == 'h28) ? 1 : 0;
      mis = (m_valid && sz > 1 && (a % sz) != 0) ? 1 : 0;
      be  = (m_valid && st != 0 && mis == 0) ? (((1 << sz) - 1) << a) : 0;
      if (op == 'h29)      sd = int'(m_rt[15:0]) * 32'h0001_0001;
      else if (op == 'h28) sd = int'(m_rt[7:0]) * 32'h0101_0101;
      else                 sd = m_rt;
      ext = 0;
      if (m_valid && mis == 0)
         case (op)
            'h21: ext = 1;
            'h20: ext = 2;
            'h25: ext = 3;
            'h24: ext = 4;
            default: ext = 0;
         endcase
      check("PC_M", PC_M, m_pc);
      check("PC_M8", PC_M8, m_pc + 32'd8);
      check("Instr_M", Instr_M, m_instr);
      check("rtData_M", rtData_M, m_rt);
      check("aluOut_M", aluOut_M, m_alu);
      check("sb_M", 32'(sb_M), 32'(m_sb));
      check("valid_M", 32'(valid_M), 32'(m_valid));
      check("ByteEn", 32'(ByteEn), be);
      check("storeData", storeData, sd);
      check("Load_extOp", 32'(Load_extOp), 32'(ext));
      check("misalign_M", 32'(misalign_M), 32'(mis));
   endtask

   // drive, clock, update model, sample 1 time unit after the edge
   task automatic cycle(input logic r, input logic s, input logic f, input logic [31:0] pc,
                        input logic [31:0] ins, input logic [31:0] rt, input logic [31:0] alu,
                        input logic [0:0] sb);
      reset = r; stall = s; flush = f; PC_E = pc; Instr_E = ins; rtData_E = rt;
      aluOut_E = alu; sb_E = sb;
      @(posedge clk);
      model_step();
      #1;
      check_model();
   endtask

   function automatic logic [31:0] mk(input logic [5:0] op);
      logic [25:0] low;
      low = 26'($urandom);
      return {op, low};
   endfunction

   initial begin
      logic [31:0] held_pc, held_instr;
      logic [5:0]  ops [10];
      ops = '{6'h2B, 6'h29, 6'h28, 6'h23, 6'h21, 6'h25, 6'h20, 6'h24, 6'h00, 6'h0F};
      reset = 1; stall = 0; flush = 0; PC_E = 0; Instr_E = 0; rtData_E = 0; aluOut_E = 0; sb_E = 0;
      m_pc = 0; m_instr = 0; m_rt = 0; m_alu = 0; m_sb = 0; m_valid = 0;

      // reset
      cycle(1, 0, 0, 32'h1111_0000, mk(6'h2B), 32'h5555_5555, 32'h0, 1'b1);
      check("rst_PC_M", PC_M, 32'h0000_3000);
      check("rst_PC_M8", PC_M8, 32'h0000_3008);
      check("rst_Instr_M", Instr_M, 32'h0);
      check("rst_valid", 32'(valid_M), 32'h0);
      check("rst_ByteEn", 32'(ByteEn), 32'h0);
      check("rst_storeData", storeData, 32'h0);

      // sb at 0x13
      cycle(0, 0, 0, 32'h3004, mk(6'h28), 32'h1234_56AB, 32'h0000_0013, 1'b1);
      check("sb_ByteEn", 32'(ByteEn), 32'b1000);
      check("sb_storeData", storeData, 32'hABAB_ABAB);
      check("sb_misalign", 32'(misalign_M), 32'h0);

      // sh aligned then misaligned
      cycle(0, 0, 0, 32'h3008, mk(6'h29), 32'hDEAD_BEEF, 32'h0000_0006, 1'b0);
      check("sh6_ByteEn", 32'(ByteEn), 32'b1100);
      check("sh6_storeData", storeData, 32'hBEEF_BEEF);
      cycle(0, 0, 0, 32'h300C, mk(6'h29), 32'hDEAD_BEEF, 32'h0000_0005, 1'b0);
      check("sh5_ByteEn", 32'(ByteEn), 32'b0000);
      check("sh5_misalign", 32'(misalign_M), 32'h1);

      // lhu then lbu
      cycle(0, 0, 0, 32'h3010, mk(6'h25), 32'h0, 32'h0000_0002, 1'b0);
      check("lhu_ext", 32'(Load_extOp), 32'b011);
      check("lhu_ByteEn", 32'(ByteEn), 32'b0000);
      cycle(0, 0, 0, 32'h3014, mk(6'h24), 32'h0, 32'h0000_0003, 1'b0);
      check("lbu_ext", 32'(Load_extOp), 32'b100);
      check("lbu_ByteEn", 32'(ByteEn), 32'b0000);

      // sw then stall with changing E inputs
      cycle(0, 0, 0, 32'h3018, mk(6'h2B), 32'hCAFE_F00D, 32'h0000_0100, 1'b1);
      held_pc = PC_M; held_instr = Instr_M;
      for (int i = 0; i < 3; i++) begin
         cycle(0, 1, 0, $urandom, mk(6'h28), $urandom, $urandom, 1'(i));
         check("stall_ByteEn", 32'(ByteEn), 32'b1111);
         check("stall_PC_M", PC_M, 32'h3018);
         check("stall_storeData", storeData, 32'hCAFE_F00D);
      end

      // stall and flush together
      cycle(0, 1, 1, 32'h3040, mk(6'h2B), 32'h1, 32'h0, 1'b1);
      check("sf_Instr_M", Instr_M, 32'h0);
      check("sf_valid", 32'(valid_M), 32'h0);
      check("sf_PC_M", PC_M, 32'h3040);
      check("sf_PC_M8", PC_M8, 32'h3048);
      check("sf_ByteEn", 32'(ByteEn), 32'h0);

      // PC_M8 wraps
      cycle(0, 0, 0, 32'hFFFF_FFFC, mk(6'h00), 32'h0, 32'h0, 1'b0);
      check("wrap_PC_M8", PC_M8, 32'h0000_0004);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic [31:0] alu;
         alu = $urandom;
         cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 7) == 0), $urandom, mk(ops[$urandom_range(0, 9)]),
               $urandom, alu, 1'($urandom));
      end

      // reset overrides simultaneous stall and flush
      cycle(0, 0, 0, 32'h4000, mk(6'h23), 32'h9, 32'h4, 1'b1);
      cycle(1, 1, 1, 32'h5000, mk(6'h2B), 32'h9, 32'h8, 1'b1);
      check("rst_over_PC_M", PC_M, 32'h0000_3000);
      check("rst_over_valid", 32'(valid_M), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
